servo_pwm_multi: RTL and testbench
==================================

Name: servo_pwm_multi

Overview:
- Multi-channel hobby-servo PWM controller; successor to the single-channel servo driver.
- Accepts ASCII position commands ('1'..'4') per channel over a valid/ready interface.
- Ramps each channel's pulse width toward its target at a programmable step and rate, and drives one PWM output per channel.
- Sits between the UART byte receiver and the servo pins; exports per-channel at-target and position flags for the LED/status logic.

Parameters:
- NUM_CH, 4, number of servo channels (1..8).
- CW, 21, width of the period counter and pulse-width registers.
- PERIOD, 1_000_000, PWM period in clk cycles (20 ms at 50 MHz).
- RAMP_DIV, 850_000, clk cycles between ramp ticks.
- STEP, 1000, pulse-width change per ramp tick, in cycles.
- POS0, 124_000, pulse width for code '1' (also the reset width).
- POS1, 90_000, pulse width for code '2'.
- POS2, 55_000, pulse width for code '3'.
- POS3, 20_000, pulse width for code '4'.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  command can be accepted
- cmd_ch  in  $clog2(NUM_CH) (min 1)  target channel
- cmd_code  in  8  ASCII code; 8'd49..8'd52 = POS0..POS3
- ch_en  in  NUM_CH  per-channel output enable
- pwm_out  out  NUM_CH  servo PWM, registered
- at_target  out  NUM_CH  current width == target width
- pos_onehot  out  4*NUM_CH  per channel {POS3,POS2,POS1,POS0} one-hot of current width; 0 while between positions
- cmd_err  out  1  one-cycle pulse on a rejected command

Behaviour:
- Reset (sampled on the clk edge while rst=1):
  - cur, tgt and shadow = POS0 on all channels.
  - Period counter and ramp divider = 0.
  - pwm_out = 0, at_target = all 1, pos_onehot = 4'b0001 per channel, cmd_err = 0, cmd_ready = 0.
  - cmd_ready = 1 from the first cycle after rst falls. Reset mid-ramp aborts the ramp immediately.
- Period counter: counts 0..PERIOD-1, then wraps to 0.
- Ramp divider: counts 0..RAMP_DIV-1; a single-cycle tick is asserted when it equals RAMP_DIV-1.
- Command handshake:
  - Accept when cmd_valid && cmd_ready; cmd_ready is constant 1 outside reset.
  - Valid code with cmd_ch < NUM_CH: tgt[cmd_ch] is updated on the accept edge.
  - Any other code, or cmd_ch >= NUM_CH: cmd_err pulses high the next cycle; no state changes.
- Ramp, per channel, on a tick only:
  - cur < tgt: cur = min(cur+STEP, tgt).
  - cur > tgt: cur = max(cur-STEP, tgt).
  - cur == tgt: hold.
  - Clamping means cur never overshoots the target. Arithmetic is done at CW+1 bits to avoid wrap.
- Simultaneous command and tick: the tick uses the pre-command tgt; the new tgt takes effect from the next tick.
- Glitch-free update: shadow = cur is loaded only on the cycle where the period counter = PERIOD-1. A width change therefore never truncates or extends a pulse in progress.
- PWM output:
  - pwm_out[i] <= ch_en[i] && (cnt < shadow[i]).
  - High time is exactly shadow cycles per period; output is registered with 1-cycle latency from the counter.
  - shadow = 0 gives constant low; shadow >= PERIOD gives constant high.
- ch_en:
  - Deassert: pwm_out forced to 0 from the next cycle.
  - While disabled, cur/tgt still ramp and commands are still accepted.
  - Re-enable takes effect from the next cycle.
- at_target and pos_onehot are registered and derived from cur, updated one cycle after cur changes.
- Parameter legality (checked at elaboration): all POSx <= PERIOD < 2^CW, STEP >= 1.

Decomposition:
- Package servo_pkg holds:
  - ASCII code constants CODE_P0..CODE_P3 (49..52).
  - A code-to-index function returning a valid flag plus a 2-bit index.
  - The POS index encoding used by pos_onehot.
- Top-level servo_pwm_multi holds the shared period counter, ramp divider, command decode and error pulse.
- Sub-module servo_ch, instantiated NUM_CH times, holds:
  - the tgt/cur/shadow registers,
  - the clamped ramp logic,
  - the PWM compare,
  - the at_target and pos_onehot flags.

Test Plan:
- All scenarios use sim parameters NUM_CH=4, PERIOD=100, RAMP_DIV=10, STEP=5, POS0=60, POS1=45, POS2=30, POS3=15.
- Reset, then idle with ch_en=4'hF -> every pwm_out is high for exactly 60 of each 100 cycles; at_target=4'hF; pos_onehot=16'h1111; cmd_ready=1 one cycle after rst falls.
- Command ch1 '4' (52) -> cur[1] steps 60,55,...,15 over 9 ticks; at_target[1]=0 during the ramp, 1 after; pos_onehot[1] goes 0001 -> 0000 -> 1000; pwm high time only changes at period boundaries.
- Same test with STEP=7 and ch2 '4' -> cur[2] goes 60,53,...,18,15 (clamped, no overshoot) and stays at 15.
- Code 'A' (65) on ch0, then code '2' with cmd_ch=3 but NUM_CH=3 -> one cmd_err pulse each; no tgt or pwm change on any channel.
- Command issued on the same cycle as a tick, then rst asserted mid-ramp -> that tick ignores the new target; after reset all channels return to 60 with pwm_out=0 during reset.
- ch_en[0]=0 during a ramp -> pwm_out[0]=0 while cur[0] keeps ramping; on re-enable, pwm resumes at the current shadow width.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM controller: command codes,
// position index encoding and the code decoder.
package servo_pkg;

  // ASCII position commands '1'..'4'
  localparam logic [7:0] CODE_P0 = 8'd49;
  localparam logic [7:0] CODE_P1 = 8'd50;
  localparam logic [7:0] CODE_P2 = 8'd51;
  localparam logic [7:0] CODE_P3 = 8'd52;

  // Position index; bit k of a channel's pos_onehot nibble marks position k
  typedef enum logic [1:0] {
    PosIdx0 = 2'd0,
    PosIdx1 = 2'd1,
    PosIdx2 = 2'd2,
    PosIdx3 = 2'd3
  } pos_idx_e;

  typedef struct packed {
    logic     valid;
    pos_idx_e idx;
  } code_dec_t;

  // Translate an ASCII command byte into a position index plus a valid flag.
  function automatic code_dec_t code_to_idx(input logic [7:0] code);
    code_dec_t d;
    d.valid = 1'b0;
    d.idx   = PosIdx0;
    case (code)
      CODE_P0: begin d.valid = 1'b1; d.idx = PosIdx0; end
      CODE_P1: begin d.valid = 1'b1; d.idx = PosIdx1; end
      CODE_P2: begin d.valid = 1'b1; d.idx = PosIdx2; end
      CODE_P3: begin d.valid = 1'b1; d.idx = PosIdx3; end
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/servo_ch.sv
// One servo channel: target/current/shadow widths, clamped ramp toward the target,
// registered PWM compare and the at-target / position status flags.
module servo_ch
  import servo_pkg::*;
#(
  parameter int unsigned CW   = 21,
  parameter int unsigned STEP = 1000,
  parameter int unsigned POS0 = 124_000,
  parameter int unsigned POS1 = 90_000,
  parameter int unsigned POS2 = 55_000,
  parameter int unsigned POS3 = 20_000
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_tick,
  input  logic          i_period_end,
  input  logic [CW-1:0] i_cnt,
  input  logic          i_tgt_we,
  input  pos_idx_e      i_tgt_idx,
  input  logic          i_en,
  output logic          o_pwm,
  output logic          o_at_target,
  output logic [3:0]    o_pos_onehot
);

  localparam logic [CW-1:0] P0     = CW'(POS0);
  localparam logic [CW-1:0] P1     = CW'(POS1);
  localparam logic [CW-1:0] P2     = CW'(POS2);
  localparam logic [CW-1:0] P3     = CW'(POS3);
  localparam logic [CW:0]   STEP_X = (CW+1)'(STEP);

  logic [CW-1:0] r_tgt, r_cur, r_shadow;
  logic          r_pwm, r_at_target;
  logic [3:0]    r_pos_onehot;
  logic [CW-1:0] w_new_tgt, w_cur_next;
  logic [CW:0]   w_up, w_dn_lim;

  // Map the decoded command index onto its pulse width.
  always_comb begin
    w_new_tgt = P0;
    case (i_tgt_idx)
      PosIdx0: w_new_tgt = P0;
      PosIdx1: w_new_tgt = P1;
      PosIdx2: w_new_tgt = P2;
      PosIdx3: w_new_tgt = P3;
      default: w_new_tgt = P0;
    endcase
  end

  // Clamped step toward the target; one extra bit keeps the sums from wrapping.
  always_comb begin
    w_up       = {1'b0, r_cur} + STEP_X;
    w_dn_lim   = {1'b0, r_tgt} + STEP_X;
    w_cur_next = r_cur;
    if (r_cur < r_tgt) begin
      w_cur_next = (w_up >= {1'b0, r_tgt}) ? r_tgt : w_up[CW-1:0];
    end else if (r_cur > r_tgt) begin
      w_cur_next = ({1'b0, r_cur} <= w_dn_lim) ? r_tgt : r_cur - STEP_X[CW-1:0];
    end
  end

  // Width state: target on accept, current on ramp ticks, shadow only at period end.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tgt    <= P0;
      r_cur    <= P0;
      r_shadow <= P0;
    end else begin
      if (i_tgt_we)     r_tgt    <= w_new_tgt;
      if (i_tick)       r_cur    <= w_cur_next;
      if (i_period_end) r_shadow <= r_cur;
    end
  end

  // Registered PWM output and status flags derived from the current width.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pwm        <= 1'b0;
      r_at_target  <= 1'b1;
      r_pos_onehot <= 4'b0001;
    end else begin
      r_pwm        <= i_en && (i_cnt < r_shadow);
      r_at_target  <= (r_cur == r_tgt);
      r_pos_onehot <= {r_cur == P3, r_cur == P2, r_cur == P1, r_cur == P0};
    end
  end

  assign o_pwm        = r_pwm;
  assign o_at_target  = r_at_target;
  assign o_pos_onehot = r_pos_onehot;

endmodule

// File: rtl/servo_pwm_multi.sv
// Multi-channel servo PWM controller: shared period counter and ramp divider,
// ASCII command decode with error pulse, and one servo_ch per channel.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CW       = 21,
  parameter int unsigned PERIOD   = 1_000_000,
  parameter int unsigned RAMP_DIV = 850_000,
  parameter int unsigned STEP     = 1000,
  parameter int unsigned POS0     = 124_000,
  parameter int unsigned POS1     = 90_000,
  parameter int unsigned POS2     = 55_000,
  parameter int unsigned POS3     = 20_000
) (
  input  logic                                       i_clk,
  input  logic                                       i_rst,
  input  logic                                       i_cmd_valid,
  output logic                                       o_cmd_ready,
  input  logic [$clog2(NUM_CH > 1 ? NUM_CH : 2)-1:0] i_cmd_ch,
  input  logic [7:0]                                 i_cmd_code,
  input  logic [NUM_CH-1:0]                          i_ch_en,
  output logic [NUM_CH-1:0]                          o_pwm_out,
  output logic [NUM_CH-1:0]                          o_at_target,
  output logic [4*NUM_CH-1:0]                        o_pos_onehot,
  output logic                                       o_cmd_err
);

  localparam int unsigned   DW       = $clog2(RAMP_DIV + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(RAMP_DIV - 1);

  if (POS0 > PERIOD || POS1 > PERIOD || POS2 > PERIOD || POS3 > PERIOD ||
      64'(PERIOD) >= (64'd1 << CW) || STEP < 1 || RAMP_DIV < 1 ||
      NUM_CH < 1 || NUM_CH > 8) begin : g_param_check
    $error("servo_pwm_multi: illegal parameter set");
  end

  logic [CW-1:0]     r_cnt;
  logic [DW-1:0]     r_div;
  logic              r_ready, r_err;
  logic              w_period_end, w_tick, w_accept, w_ch_ok;
  code_dec_t         w_dec;
  logic [NUM_CH-1:0] w_tgt_we;

  assign w_period_end = (r_cnt == CNT_LAST);
  assign w_tick       = (r_div == DIV_LAST);

  // Shared period counter and ramp-tick divider.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
      r_div <= '0;
    end else begin
      r_cnt <= w_period_end ? '0 : r_cnt + 1'b1;
      r_div <= w_tick ? '0 : r_div + 1'b1;
    end
  end

  // Command decode: an accepted, legal command becomes a one-channel target write.
  always_comb begin
    w_dec    = code_to_idx(i_cmd_code);
    w_accept = i_cmd_valid && r_ready;
    w_ch_ok  = 32'(i_cmd_ch) < NUM_CH;
    w_tgt_we = '0;
    for (int i = 0; i < int'(NUM_CH); i++) begin
      w_tgt_we[i] = w_accept && w_dec.valid && w_ch_ok && (32'(i_cmd_ch) == 32'(i));
    end
  end

  // Ready rises the cycle after reset releases; a rejected command pulses cmd_err.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_accept && !(w_dec.valid && w_ch_ok);
    end
  end

  assign o_cmd_ready = r_ready;
  assign o_cmd_err   = r_err;

  for (genvar i = 0; i < int'(NUM_CH); i++) begin : g_ch
    servo_ch #(
      .CW  (CW),
      .STEP(STEP),
      .POS0(POS0),
      .POS1(POS1),
      .POS2(POS2),
      .POS3(POS3)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_tick      (w_tick),
      .i_period_end(w_period_end),
      .i_cnt       (r_cnt),
      .i_tgt_we    (w_tgt_we[i]),
      .i_tgt_idx   (w_dec.idx),
      .i_en        (i_ch_en[i]),
      .o_pwm       (o_pwm_out[i]),
      .o_at_target (o_at_target[i]),
      .o_pos_onehot(o_pos_onehot[4*i +: 4])
    );
  end

endmodule

// File: tb/tb_servo_pwm_multi.sv
// Bench for servo_pwm_multi: two instances (4 ch / STEP 5 and 3 ch / STEP 7) share one
// stimulus stream; a behavioural model is compared every cycle, plus literal spot checks.
module tb_servo_pwm_multi;

  localparam int P_PERIOD = 100;
  localparam int P_DIV    = 10;

  logic       clk = 1'b0;
  logic       rst, valid;
  logic [1:0] cmd_ch;
  logic [7:0] code;
  logic [3:0] en;

  logic        rdy_a, err_a, rdy_b, err_b;
  logic [3:0]  pwm_a, at_a;
  logic [15:0] oh_a;
  logic [2:0]  pwm_b, at_b;
  logic [11:0] oh_b;

  always #5 clk = ~clk;

  servo_pwm_multi #(
    .NUM_CH(4), .CW(8), .PERIOD(P_PERIOD), .RAMP_DIV(P_DIV), .STEP(5),
    .POS0(60), .POS1(45), .POS2(30), .POS3(15)
  ) dut_a (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(rdy_a),
    .i_cmd_ch(cmd_ch), .i_cmd_code(code), .i_ch_en(en), .o_pwm_out(pwm_a),
    .o_at_target(at_a), .o_pos_onehot(oh_a), .o_cmd_err(err_a)
  );

  servo_pwm_multi #(
    .NUM_CH(3), .CW(8), .PERIOD(P_PERIOD), .RAMP_DIV(P_DIV), .STEP(7),
    .POS0(60), .POS1(45), .POS2(30), .POS3(15)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_cmd_valid(valid), .o_cmd_ready(rdy_b),
    .i_cmd_ch(cmd_ch), .i_cmd_code(code), .i_ch_en(en[2:0]), .o_pwm_out(pwm_b),
    .o_at_target(at_b), .o_pos_onehot(oh_b), .o_cmd_err(err_b)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cur[2][4], m_tgt[2][4], m_sh[2][4];
  bit         e_pwm[2][4], e_at[2][4];
  logic [3:0] e_oh[2][4];
  bit         e_err[2];
  bit         e_rdy;
  int         m_cnt, m_div;
  bit         m_live = 1'b0;

  function automatic int step_of(input int k);
    return (k == 0) ? 5 : 7;
  endfunction

  function automatic int nch_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  function automatic int pos_w(input int idx);
    case (idx)
      0: return 60;
      1: return 45;
      2: return 30;
      default: return 15;
    endcase
  endfunction

  function automatic logic [3:0] onehot_of(input int w);
    return {w == 15, w == 30, w == 45, w == 60};
  endfunction

  function automatic int ramp(input int cur, input int tgt, input int st);
    if (cur < tgt) return (cur + st > tgt) ? tgt : cur + st;
    if (cur > tgt) return (cur - st < tgt) ? tgt : cur - st;
    return cur;
  endfunction

  task automatic model_step();
    bit tick, pend, acc, ok;
    int ci;
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          m_cur[k][c] = 60; m_tgt[k][c] = 60; m_sh[k][c] = 60;
          e_pwm[k][c] = 1'b0; e_at[k][c] = 1'b1; e_oh[k][c] = 4'b0001;
        end
        e_err[k] = 1'b0;
      end
      m_cnt = 0; m_div = 0; e_rdy = 1'b0;
    end else begin
      tick = (m_div == P_DIV - 1);
      pend = (m_cnt == P_PERIOD - 1);
      acc  = valid && e_rdy;
      ci   = int'(cmd_ch);
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < 4; c++) begin
          e_pwm[k][c] = en[c] && (m_cnt < m_sh[k][c]);
          e_at[k][c]  = (m_cur[k][c] == m_tgt[k][c]);
          e_oh[k][c]  = onehot_of(m_cur[k][c]);
          if (pend) m_sh[k][c] = m_cur[k][c];
          if (tick) m_cur[k][c] = ramp(m_cur[k][c], m_tgt[k][c], step_of(k));
        end
        ok = (code >= 8'd49) && (code <= 8'd52) && (ci < nch_of(k));
        if (acc && ok) m_tgt[k][ci] = pos_w(int'(code) - 49);
        e_err[k] = acc && !ok;
      end
      m_cnt = pend ? 0 : m_cnt + 1;
      m_div = tick ? 0 : m_div + 1;
      e_rdy = 1'b1;
    end
    m_live = 1'b1;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [3:0]  xp, xa, ap, aa;
    logic [15:0] xo, ao;
    logic        ae, ar;
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        xp = '0; xa = '0; xo = '0;
        for (int c = 0; c < nch_of(k); c++) begin
          xp[c] = e_pwm[k][c];
          xa[c] = e_at[k][c];
          xo[4*c +: 4] = e_oh[k][c];
        end
        if (k == 0) begin
          ap = pwm_a; aa = at_a; ao = oh_a; ae = err_a; ar = rdy_a;
        end else begin
          ap = {1'b0, pwm_b}; aa = {1'b0, at_b}; ao = {4'b0, oh_b}; ae = err_b; ar = rdy_b;
        end
        chk($sformatf("model pwm_out dut%0d", k), 32'(ap), 32'(xp));
        chk($sformatf("model at_target dut%0d", k), 32'(aa), 32'(xa));
        chk($sformatf("model pos_onehot dut%0d", k), 32'(ao), 32'(xo));
        chk($sformatf("model cmd_err dut%0d", k), 32'(ae), 32'(e_err[k]));
        chk($sformatf("model cmd_ready dut%0d", k), 32'(ar), 32'(e_rdy));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [1:0] ch, input logic [7:0] c);
    cmd_ch = ch; code = c; valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic high_count(input int k, input int c, output int n);
    n = 0;
    for (int i = 0; i < P_PERIOD; i++) begin
      @(negedge clk);
      if (k == 0) begin
        if (pwm_a[c[1:0]] === 1'b1) n++;
      end else begin
        if (pwm_b[c[1:0]] === 1'b1) n++;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n;
    bit  ok;
    rst = 1'b1; valid = 1'b0; cmd_ch = 2'd0; code = 8'd0; en = 4'hF;
    repeat (3) @(negedge clk);
    chk("reset cmd_ready", 32'(rdy_a), 32'd0);
    chk("reset pwm_out", 32'(pwm_a), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready after reset", 32'(rdy_a), 32'd1);
    chk("idle pos_onehot", 32'(oh_a), 32'h1111);
    chk("idle at_target", 32'(at_a), 32'hF);

    // Idle: 60 high cycles out of every 100
    high_count(0, 0, n);
    chk("idle high ch0", 32'(n), 32'd60);
    high_count(1, 2, n);
    chk("idle high dutb ch2", 32'(n), 32'd60);

    // ch1 -> '4': ramp 60 down to 15
    send(2'd1, 8'd52);
    @(negedge clk);
    chk("ch1 at_target drops", 32'(at_a[1]), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (oh_a[7:4] == 4'b0000) ok = 1'b1;
    end
    chk("ch1 leaves POS0", 32'(ok), 32'd1);
    repeat (250) @(negedge clk);
    chk("ch1 final onehot", 32'(oh_a[7:4]), 32'h8);
    chk("ch1 final at_target", 32'(at_a[1]), 32'd1);
    high_count(0, 1, n);
    chk("ch1 final high", 32'(n), 32'd15);
    chk("dutb ch1 final onehot", 32'(oh_b[7:4]), 32'h8);

    // ch2 -> '4' with STEP 7 on dut_b: clamps 18 -> 15
    send(2'd2, 8'd52);
    repeat (20) @(negedge clk);
    chk("dutb ch2 between positions", 32'(oh_b[11:8]), 32'h0);
    repeat (250) @(negedge clk);
    chk("dutb ch2 final onehot", 32'(oh_b[11:8]), 32'h8);
    high_count(1, 2, n);
    chk("dutb ch2 final high", 32'(n), 32'd15);

    // Rejected commands
    send(2'd0, 8'd65);
    chk("bad code err a", 32'(err_a), 32'd1);
    chk("bad code err b", 32'(err_b), 32'd1);
    @(negedge clk);
    chk("err is one cycle", 32'(err_a), 32'd0);
    send(2'd3, 8'd50);
    chk("ch3 rejected on 3ch", 32'(err_b), 32'd1);
    chk("ch3 accepted on 4ch", 32'(err_a), 32'd0);
    repeat (50) @(negedge clk);
    chk("dutb untouched at_target", 32'(at_b), 32'h7);
    chk("dutb ch0 untouched", 32'(oh_b[3:0]), 32'h1);

    // Command on the tick edge: that tick must ignore the new target
    ok = 1'b0;
    for (int i = 0; i < 2 * P_DIV && !ok; i++) begin
      if (m_div == P_DIV - 1) ok = 1'b1;
      else @(negedge clk);
    end
    chk("tick alignment found", 32'(ok), 32'd1);
    send(2'd0, 8'd50);
    repeat (4) @(negedge clk);
    chk("tick ignores new tgt", 32'(oh_a[3:0]), 32'h1);
    chk("ch0 ramp pending", 32'(at_a[0]), 32'd0);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("pwm low in reset a", 32'(pwm_a), 32'd0);
    chk("pwm low in reset b", 32'(pwm_b), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post reset onehot a", 32'(oh_a), 32'h1111);
    chk("post reset onehot b", 32'(oh_b), 32'h111);
    chk("post reset at_target", 32'(at_a), 32'hF);

    // Disable ch0 during a ramp, re-enable afterwards
    send(2'd0, 8'd52);
    repeat (15) @(negedge clk);
    en = 4'hE;
    high_count(0, 0, n);
    chk("disabled ch0 high", 32'(n), 32'd0);
    repeat (150) @(negedge clk);
    chk("ch0 ramped while disabled", 32'(oh_a[3:0]), 32'h8);
    en = 4'hF;
    high_count(0, 0, n);
    chk("reenabled ch0 high", 32'(n), 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
